hdlc_tx: RTL and testbench

- HDLC-style serial frame transmitter. It is the transmit end paired with hdlc_rx.
- Accepts bytes on a byte-stream interface with valid/ready/last signalling.
- Emits a gated serial clock clk_out and serial data data_out.
- Frame on the line: OPEN_FLAGS copies of flag 0x7E, then payload with zero-bit stuffing, then CLOSE_FLAGS copies of 0x7E, then a mandatory idle gap.

---
 rtl/hdlc_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_hdlc_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_tx.sv
// HDLC-style serial frame transmitter: opening flags, zero-bit-stuffed payload,
// closing flags and a fixed idle gap, emitted as a gated serial clock plus data.
module hdlc_tx #(
   parameter logic [7:0] FLAG        = 8'h7E,
   parameter int         OPEN_FLAGS  = 4,
   parameter int         CLOSE_FLAGS = 1,
   parameter int         BIT_PERIOD  = 4,
   parameter int         GAP_CYCLES  = 256
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tvalid,
   output logic       tready,
   input  logic [7:0] tdata,
   input  logic       tlast,
   output logic       clk_out,
   output logic       data_out,
   output logic       busy,
   output logic       underrun,
   output logic       finish,
   output logic [2:0] dbg_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_OPEN  = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STUFF = 3'd3;
   localparam logic [2:0] S_CLOSE = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;

   localparam int MAXF = (OPEN_FLAGS > CLOSE_FLAGS) ? OPEN_FLAGS : CLOSE_FLAGS;
   localparam int PW   = $clog2(BIT_PERIOD);
   localparam int FW   = (MAXF > 1) ? $clog2(MAXF) : 1;
   localparam int GW   = $clog2(GAP_CYCLES);

   localparam logic [PW-1:0] PH_LAST    = PW'(BIT_PERIOD - 1);
   localparam logic [PW-1:0] PH_HALF    = PW'(BIT_PERIOD / 2);
   localparam logic [FW-1:0] OPEN_LAST  = FW'(OPEN_FLAGS - 1);
   localparam logic [FW-1:0] CLOSE_LAST = FW'(CLOSE_FLAGS - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [2:0]    bit_q, bit_d;
   logic [FW-1:0] flag_q, flag_d;
   logic [2:0]    ones_q, ones_d;
   logic [7:0]    cur_q, cur_d;
   logic          cur_last_q, cur_last_d;
   logic [7:0]    nxt_q, nxt_d;
   logic          nxt_last_q, nxt_last_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          data_q, data_d;
   logic          clk_q, clk_d;

   logic active, ph0, ph_end, advance;

   assign active = (state_q == S_OPEN) || (state_q == S_DATA) ||
                   (state_q == S_STUFF) || (state_q == S_CLOSE);
   assign ph0    = (phase_q == '0);
   assign ph_end = (phase_q == PH_LAST);

   // Handshake: tready is combinational and a byte is taken on every rising edge
   // where tvalid && tready. tready only rises in IDLE or at phase 0 of the LSB
   // slot of a non-final byte; tvalid is ignored everywhere else.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      flag_d     = flag_q;
      ones_d     = ones_q;
      cur_d      = cur_q;
      cur_last_d = cur_last_q;
      nxt_d      = nxt_q;
      nxt_last_d = nxt_last_q;
      gap_d      = gap_q;
      data_d     = data_q;
      clk_d      = 1'b0;
      tready     = 1'b0;
      underrun   = 1'b0;
      finish     = 1'b0;
      advance    = 1'b0;

      if (active) begin
         phase_d = ph_end ? '0 : phase_q + 1'b1;
         clk_d   = (phase_q >= PH_HALF);
      end

      case (state_q)
         S_IDLE: begin
            data_d = 1'b1;
            if (tvalid) begin
               tready     = 1'b1;
               cur_d      = tdata;
               cur_last_d = tlast;
               phase_d    = '0;
               bit_d      = '0;
               flag_d     = '0;
               ones_d     = '0;
               state_d    = S_OPEN;
            end
         end
         S_OPEN: begin
            if (ph0) data_d = FLAG[3'd7 - bit_q];
            if (ph_end) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
                  if (flag_q == OPEN_LAST) begin
                     flag_d  = '0;
                     state_d = S_DATA;
                  end else begin
                     flag_d = flag_q + 1'b1;
                  end
               end
            end
         end
         S_DATA: begin
            if (ph0) begin
               data_d = cur_q[3'd7 - bit_q];
               ones_d = cur_q[3'd7 - bit_q] ? ones_q + 1'b1 : 3'd0;
               if (bit_q == 3'd7 && !cur_last_q) begin
                  if (tvalid) begin
                     tready     = 1'b1;
                     nxt_d      = tdata;
                     nxt_last_d = tlast;
                  end else begin
                     // Nothing to send next: end the frame after this byte.
                     underrun   = 1'b1;
                     cur_last_d = 1'b1;
                  end
               end
            end
            if (ph_end) begin
               if (ones_q == 3'd5) state_d = S_STUFF;
               else                advance = 1'b1;
            end
         end
         S_STUFF: begin
            if (ph0) begin
               data_d = 1'b0;
               ones_d = '0;
            end
            if (ph_end) advance = 1'b1;
         end
         S_CLOSE: begin
            if (ph0) data_d = FLAG[3'd7 - bit_q];
            if (ph_end) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
                  if (flag_q == CLOSE_LAST) begin
                     flag_d  = '0;
                     gap_d   = '0;
                     state_d = S_GAP;
                  end else begin
                     flag_d = flag_q + 1'b1;
                  end
               end
            end
         end
         S_GAP: begin
            data_d = 1'b1;
            if (gap_q == GAP_LAST) begin
               finish  = 1'b1;
               gap_d   = '0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Leaving a payload slot: next bit, next byte, or the closing flags.
      if (advance) begin
         if (bit_q == 3'd7) begin
            bit_d = '0;
            if (cur_last_q) begin
               ones_d  = '0;
               flag_d  = '0;
               state_d = S_CLOSE;
            end else begin
               cur_d      = nxt_q;
               cur_last_d = nxt_last_q;
               state_d    = S_DATA;
            end
         end else begin
            bit_d   = bit_q + 1'b1;
            state_d = S_DATA;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         bit_q      <= '0;
         flag_q     <= '0;
         ones_q     <= '0;
         cur_q      <= '0;
         cur_last_q <= 1'b0;
         nxt_q      <= '0;
         nxt_last_q <= 1'b0;
         gap_q      <= '0;
         data_q     <= 1'b1;
         clk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         flag_q     <= flag_d;
         ones_q     <= ones_d;
         cur_q      <= cur_d;
         cur_last_q <= cur_last_d;
         nxt_q      <= nxt_d;
         nxt_last_q <= nxt_last_d;
         gap_q      <= gap_d;
         data_q     <= data_d;
         clk_q      <= clk_d;
      end
   end

   assign clk_out   = clk_q;
   assign data_out  = data_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_hdlc_tx.sv
// Bench for hdlc_tx: a frame-level model builds the line bit string and the
// cycle schedule of every output, and a compare process checks each cycle.
module tb_hdlc_tx;

   localparam int BP  = 4;
   localparam int GAP = 256;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       tvalid = 1'b0;
   logic [7:0] tdata = 8'h00;
   logic       tlast = 1'b0;
   logic       tready, clk_out, data_out, busy, underrun, finish;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   hdlc_tx dut (
      .clk(clk), .rstn(rstn), .tvalid(tvalid), .tready(tready),
      .tdata(tdata), .tlast(tlast), .clk_out(clk_out), .data_out(data_out),
      .busy(busy), .underrun(underrun), .finish(finish), .dbg_state(dbg_state)
   );

   int total = 0;
   int bad = 0;
   int frame_id = 0;
   int busy_cnt = 0;
   int fin_cnt = 0;

   // expected {not_idle, tready, underrun, busy, finish, clk_out, data_out}
   logic [6:0] exp_q[$];
   int         tag_q[$];
   logic [6:0] cmp_e, cmp_g;
   int         cmp_tag;

   logic [7:0] frame_b[16];
   logic       line_q[$];
   int         fetch_c[$];
   int         ur_c;
   logic [7:0] flag_v = 8'h7E;

   localparam logic [6:0] IDLE_V = 7'b0000001;

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      #2;
      if (exp_q.size() > 0) begin
         cmp_e   = exp_q.pop_front();
         cmp_tag = tag_q.pop_front();
         cmp_g   = {(dbg_state != 3'd0), tready, underrun, busy, finish, clk_out, data_out};
         total++;
         if (cmp_g !== cmp_e) begin
            bad++;
            if (bad <= 20)
               $display("FAIL cycle frame=%0d c=%0d got=%b exp=%b (busy_state,tready,underrun,busy,finish,clk_out,data_out)",
                        cmp_tag / 10000, cmp_tag % 10000, cmp_g, cmp_e);
         end
         if (busy) busy_cnt++;
         if (finish) fin_cnt++;
      end
   end

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // ---------------- model ----------------
   task automatic model_frame(input int n, input bit ur);
      int ones;
      logic bt;
      line_q.delete();
      fetch_c.delete();
      ur_c = -1;
      for (int f = 0; f < 4; f++)
         for (int b = 7; b >= 0; b--) line_q.push_back(flag_v[b]);
      ones = 0;
      for (int j = 0; j < n; j++) begin
         for (int b = 7; b >= 0; b--) begin
            bt = frame_b[j][b];
            line_q.push_back(bt);
            ones = bt ? ones + 1 : 0;
            if (b == 0) begin
               if (j < n - 1) fetch_c.push_back((line_q.size() - 1) * BP + 1);
               else if (ur)   ur_c = (line_q.size() - 1) * BP + 1;
            end
            if (ones == 5) begin
               line_q.push_back(1'b0);
               ones = 0;
            end
         end
      end
      for (int b = 7; b >= 0; b--) line_q.push_back(flag_v[b]);
   endtask

   function automatic int fetch_idx(input int c);
      for (int i = 0; i < fetch_c.size(); i++) if (fetch_c[i] == c) return i;
      return -1;
   endfunction

   // c counts cycles from the accepting cycle (c=0); outputs are registered.
   function automatic logic [6:0] exp_at(input int c);
      int  nbits;
      logic act, d, ck, bz, fn, tr, un;
      nbits = line_q.size();
      act = (c >= 2) && (c < 2 + nbits * BP);
      d   = act ? line_q[(c - 2) / BP] : 1'b1;
      ck  = act && (((c - 2) % BP) >= BP / 2);
      bz  = (c >= 1) && (c <= nbits * BP + GAP);
      fn  = (c == nbits * BP + GAP);
      tr  = (c == 0) || (fetch_idx(c) >= 0);
      un  = (c == ur_c);
      return {bz, tr, un, bz, fn, ck, d};
   endfunction

   function automatic int bits(input int lo, input int len);
      int r = 0;
      for (int i = 0; i < len; i++) r = (r << 1) | int'(line_q[lo + i]);
      return r;
   endfunction

   // ---------------- drivers ----------------
   task automatic run_frame(input int n, input bit ur, input int abort_at);
      int last_c, fi;
      model_frame(n, ur);
      last_c = line_q.size() * BP + GAP;
      frame_id++;
      for (int c = 0; c <= last_c; c++) begin
         if (abort_at >= 0 && c > abort_at) break;
         @(negedge clk);
         fi = fetch_idx(c);
         if (c == 0) begin
            tvalid = 1'b1; tdata = frame_b[0]; tlast = (n == 1) && !ur;
         end else if (fi >= 0) begin
            tvalid = 1'b1; tdata = frame_b[fi + 1]; tlast = (fi + 1 == n - 1) && !ur;
         end else if (c == ur_c) begin
            tvalid = 1'b0; tdata = 8'($urandom_range(0, 255));
         end else begin
            tvalid = 1'($urandom_range(0, 1));
            tdata  = 8'($urandom_range(0, 255));
            tlast  = 1'($urandom_range(0, 1));
         end
         exp_q.push_back(exp_at(c));
         tag_q.push_back(frame_id * 10000 + c);
      end
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         tvalid = 1'b0; tlast = 1'b0;
         exp_q.push_back(IDLE_V);
         tag_q.push_back(frame_id * 10000 + 9999);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rstn = 1'b0; tvalid = 1'b0; tlast = 1'b0;
      exp_q.push_back(IDLE_V); tag_q.push_back(frame_id * 10000 + 9998);
      @(negedge clk);
      exp_q.push_back(IDLE_V); tag_q.push_back(frame_id * 10000 + 9998);
      @(negedge clk);
      rstn = 1'b1;
      exp_q.push_back(IDLE_V); tag_q.push_back(frame_id * 10000 + 9998);
   endtask

   function automatic logic [7:0] pick_byte();
      case ($urandom_range(0, 5))
         0: return 8'hFF;
         1: return 8'h1F;
         2: return 8'hF8;
         3: return 8'h7E;
         4: return 8'h00;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // ---------------- sequence ----------------
   initial begin
      int n;
      bit ur;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         exp_q.push_back(IDLE_V); tag_q.push_back(9998);
      end
      rstn = 1'b1;
      idle_cycles(2);

      // single byte 0x55
      frame_b[0] = 8'h55;
      model_frame(1, 1'b0);
      check("len_55", line_q.size(), 48);
      check("pay_55", bits(32, 8), 8'h55);
      idle_cycles(1);
      busy_cnt = 0; fin_cnt = 0;
      run_frame(1, 1'b0, -1);
      idle_cycles(2);
      check("busy_cycles_55", busy_cnt, 192 + 256);
      check("finish_count_55", fin_cnt, 1);

      // 0xFF: stuff inside the byte
      frame_b[0] = 8'hFF;
      model_frame(1, 1'b0);
      check("pay_ff", bits(32, 9), 9'b111110111);
      run_frame(1, 1'b0, -1);
      idle_cycles(1);

      // ones run crossing a byte boundary, then back-to-back next frame
      frame_b[0] = 8'h1F; frame_b[1] = 8'hF8;
      model_frame(2, 1'b0);
      check("pay_1f_f8", bits(32, 18), 18'b000111110111110000);
      check("fetch_1f_f8", fetch_c[0], 39 * 4 + 1);
      run_frame(2, 1'b0, -1);

      // seven bytes, no stuffing needed
      frame_b[0] = 8'h00; frame_b[1] = 8'h05; frame_b[2] = 8'hAA; frame_b[3] = 8'hBB;
      frame_b[4] = 8'hCC; frame_b[5] = 8'hDD; frame_b[6] = 8'hEE;
      model_frame(7, 1'b0);
      check("len_7byte", line_q.size(), 96);
      run_frame(7, 1'b0, -1);
      idle_cycles(2);

      // underrun at the second fetch
      frame_b[0] = 8'h3C;
      model_frame(1, 1'b1);
      check("ur_cycle", ur_c, 157);
      check("ur_len", line_q.size(), 48);
      busy_cnt = 0;
      run_frame(1, 1'b1, -1);
      idle_cycles(2);
      check("busy_cycles_ur", busy_cnt, 192 + 256);

      // reset in the middle of the payload, then a clean frame
      for (int i = 0; i < 5; i++) frame_b[i] = pick_byte();
      run_frame(5, 1'b0, 45 * BP);
      pulse_reset();
      idle_cycles(2);
      frame_b[0] = 8'hA5; frame_b[1] = 8'h7E;
      run_frame(2, 1'b0, -1);
      idle_cycles(1);

      // randomized frames
      for (int f = 0; f < 12; f++) begin
         n  = $urandom_range(1, 5);
         ur = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < n; i++) frame_b[i] = pick_byte();
         run_frame(n, ur, -1);
         idle_cycles($urandom_range(0, 3));
      end

      idle_cycles(2);
      @(negedge clk);
      #5;
      check("drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
